// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between requester C (CPU) and D (debug/DMA).
// Round-robin between the two, one transaction in flight, all outputs registered.
module mem_port_arbiter #(
  parameter int Wwid = 32,
  parameter int aW   = 32,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [aW-1:0]   c_addr,
  input  logic [Wwid-1:0] c_wdata,
  output logic            c_done,
  output logic [Wwid-1:0] c_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [aW-1:0]   d_addr,
  input  logic [Wwid-1:0] d_wdata,
  output logic            d_done,
  output logic [Wwid-1:0] d_rdata,
  output logic [aW-1:0]   memAddr,
  output logic [Wwid-1:0] writeData,
  output logic            writeEn,
  input  logic [Wwid-1:0] readData,
  output logic            busy,
  output logic            owner
);
  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            we_q_r, we_q_s;
  logic            lg_r, lg_s;
  logic            win_s;
  logic            owner_s, we_s, busy_s, c_done_s, d_done_s;
  logic [aW-1:0]   mem_addr_s;
  logic [Wwid-1:0] wdata_s, c_rdata_s, d_rdata_s;

  // Next-state and next-output logic; owner doubles as the in-flight winner.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    we_q_s     = we_q_r;
    lg_s       = lg_r;
    owner_s    = owner;
    mem_addr_s = memAddr;
    wdata_s    = writeData;
    we_s       = 1'b0;
    busy_s     = busy;
    c_done_s   = 1'b0;
    d_done_s   = 1'b0;
    c_rdata_s  = c_rdata;
    d_rdata_s  = d_rdata;
    if (c_req && d_req) begin
      win_s = ~lg_r;
    end else begin
      win_s = d_req;
    end
    case (state_r)
      IDLE: begin
        if (c_req || d_req) begin
          state_s    = ACCESS;
          cnt_s      = CNT_LOAD;
          we_q_s     = win_s ? d_we : c_we;
          we_s       = we_q_s;
          mem_addr_s = win_s ? d_addr : c_addr;
          wdata_s    = win_s ? d_wdata : c_wdata;
          lg_s       = win_s;
          owner_s    = win_s;
          busy_s     = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_ONE) begin
          state_s = RESP;
          if (we_q_r) begin
            c_rdata_s = c_rdata;
            d_rdata_s = d_rdata;
          end else if (owner) begin
            d_rdata_s = readData;
          end else begin
            c_rdata_s = readData;
          end
          if (owner) begin
            d_done_s = 1'b1;
          end else begin
            c_done_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer and lets C win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      we_q_r    <= 1'b0;
      lg_r      <= 1'b1;
      owner     <= 1'b0;
      memAddr   <= {aW{1'b0}};
      writeData <= {Wwid{1'b0}};
      writeEn   <= 1'b0;
      busy      <= 1'b0;
      c_done    <= 1'b0;
      d_done    <= 1'b0;
      c_rdata   <= {Wwid{1'b0}};
      d_rdata   <= {Wwid{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      we_q_r    <= we_q_s;
      lg_r      <= lg_s;
      owner     <= owner_s;
      memAddr   <= mem_addr_s;
      writeData <= wdata_s;
      writeEn   <= we_s;
      busy      <= busy_s;
      c_done    <= c_done_s;
      d_done    <= d_done_s;
      c_rdata   <= c_rdata_s;
      d_rdata   <= d_rdata_s;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers queue ops per port, a monitor checks each done against a
// transaction-level memory model, round-robin rule and latency; plus a LAT=1 instance.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_done, d_req, d_we, d_done;
  logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] memAddr, writeData, readData;
  logic        writeEn, busy, owner;
  logic        c1_req, c1_we, c1_done, d1_done, mem1_we, busy1, owner1;
  logic [31:0] c1_addr, c1_wdata, c1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

  op_t         c_todo[$], d_todo[$], c_exp[$], d_exp[$];
  logic [31:0] mem [64];
  logic [31:0] mem1 [64];
  logic [31:0] ref_mem [64];
  int          cyc, total, bad, done_cnt, last_done_cyc, c_issue_cyc;
  logic        rst_samp, c_req_samp, d_req_samp;
  bit          gaps;

  mem_port_arbiter #(.Wwid(32), .aW(32), .LAT(LAT)) u0 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .memAddr(memAddr), .writeData(writeData), .writeEn(writeEn), .readData(readData),
    .busy(busy), .owner(owner));

  mem_port_arbiter #(.Wwid(32), .aW(32), .LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .c_req(c1_req), .c_we(c1_we), .c_addr(c1_addr), .c_wdata(c1_wdata), .c_done(c1_done), .c_rdata(c1_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_done(d1_done), .d_rdata(d1_rdata),
    .memAddr(mem1_addr), .writeData(mem1_wdata), .writeEn(mem1_we), .readData(mem1_rdata),
    .busy(busy1), .owner(owner1));

  assign readData   = mem[memAddr[7:2]];
  assign mem1_rdata = mem1[mem1_addr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter and posedge snapshot of what the DUT sampled.
  initial begin
    cyc = 0; rst_samp = 1'b1; c_req_samp = 1'b0; d_req_samp = 1'b0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      rst_samp = rst; c_req_samp = c_req; d_req_samp = d_req;
    end
  end

  // Memory models behind both instances.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA500_0000 | i;
      mem1[i] = 32'h0;
    end
    mem[0] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (writeEn === 1'b1) mem[memAddr[7:2]] = writeData;
      if (mem1_we === 1'b1) mem1[mem1_addr[7:2]] = mem1_wdata;
    end
  end

  // Requesters: hold an op until its done, then present the next one (or idle).
  initial begin
    op_t o;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_issue_cyc = 0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (c_done === 1'b1 || !c_req) begin
        if (c_todo.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          o = c_todo.pop_front();
          c_req = 1'b1; c_we = o.we; c_addr = o.addr; c_wdata = o.wdata;
          c_exp.push_back(o); c_issue_cyc = cyc;
        end else begin
          c_req = 1'b0; c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
        end
      end
      if (d_done === 1'b1 || !d_req) begin
        if (d_todo.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          o = d_todo.pop_front();
          d_req = 1'b1; d_we = o.we; d_addr = o.addr; d_wdata = o.wdata;
          d_exp.push_back(o);
        end else begin
          d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        end
      end
    end
  end

  // Monitor: grant rule, write strobe, done latency and read data against the model.
  initial begin
    op_t         o;
    int          grant_cyc, wr_cnt;
    bit          lg_m, exp_owner, port, busy_prev;
    logic [31:0] wr_addr, wr_data, c_rd_m, d_rd_m;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
    ref_mem[0] = 32'hDEADBEEF;
    done_cnt = 0; last_done_cyc = 0; grant_cyc = 0; wr_cnt = 0;
    lg_m = 1'b1; busy_prev = 1'b0; c_rd_m = 32'h0; d_rd_m = 32'h0;
    wr_addr = 32'h0; wr_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_samp) begin
        lg_m = 1'b1; busy_prev = 1'b0; wr_cnt = 0; c_rd_m = 32'h0; d_rd_m = 32'h0;
      end else begin
        if (busy === 1'b1 && !busy_prev) begin
          grant_cyc = cyc;
          exp_owner = (c_req_samp && d_req_samp) ? ~lg_m : d_req_samp;
          check("grant_owner", owner, exp_owner);
          lg_m = exp_owner;
          if ((exp_owner ? d_exp.size() : c_exp.size()) == 0) begin
            total++; bad++;
            $display("FAIL grant_without_op: got grant for port %0d expected none", exp_owner);
          end else begin
            check("grant_addr", memAddr, exp_owner ? d_exp[0].addr : c_exp[0].addr);
          end
        end
        if (writeEn === 1'b1) begin
          wr_cnt++; wr_addr = memAddr; wr_data = writeData;
          check("we_first_access_cycle", cyc, grant_cyc);
        end
        check("done_onehot", {31'h0, c_done & d_done}, 32'h0);
        if ((c_done ^ d_done) === 1'b1) begin
          port = d_done; done_cnt++; last_done_cyc = cyc;
          check("done_owner", owner, port);
          check("done_latency", cyc - grant_cyc, LAT);
          check("done_busy", busy, 1'b1);
          if ((port ? d_exp.size() : c_exp.size()) == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done on port %0d expected none", port);
          end else begin
            o = port ? d_exp.pop_front() : c_exp.pop_front();
            if (o.we) begin
              check("wr_pulses", wr_cnt, 1);
              check("wr_addr", wr_addr, o.addr);
              check("wr_data", wr_data, o.wdata);
              ref_mem[o.addr[7:2]] = o.wdata;
            end else begin
              check("rd_no_write", wr_cnt, 0);
              if (port) d_rd_m = ref_mem[o.addr[7:2]];
              else c_rd_m = ref_mem[o.addr[7:2]];
            end
          end
          check("c_rdata", c_rdata, c_rd_m);
          check("d_rdata", d_rdata, d_rd_m);
          wr_cnt = 0;
        end
        busy_prev = (busy === 1'b1);
      end
    end
  end

  task automatic push_op(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata;
    if (port) d_todo.push_back(o);
    else c_todo.push_back(o);
  endtask

  task automatic push_rand(input bit port);
    logic [4:0] w;
    w = 5'($urandom_range(0, 31));
    push_op(port, 1'($urandom_range(0, 1)), {25'h0, w, 2'b00}, $urandom);
  endtask

  task automatic wait_done(input bit port, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if ((port ? d_done : c_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL timeout_done: port %0d got no done expected one within %0d cycles", port, budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (c_todo.size() == 0 && d_todo.size() == 0 && c_exp.size() == 0 &&
          d_exp.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout_idle: got pending work expected drained within %0d cycles", budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, td, t0, base, t_first;
    logic [31:0] wv;
    total = 0; bad = 0; gaps = 1'b0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0; c1_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_writeData", writeData, 32'h0);
    check("rst_ctrl", {27'h0, writeEn, busy, c_done, d_done, owner}, 32'h0);
    check("rst_c_rdata", c_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;

    // Tie right after reset: C read of 0x100 wins, then D write of 0x40.
    push_op(1'b0, 1'b0, 32'h100, 32'h0);
    push_op(1'b1, 1'b1, 32'h40, 32'h12345678);
    wait_done(1'b0, 20, tc);
    check("tie_c_latency", tc - c_issue_cyc, LAT + 1);
    check("tie_c_rdata", c_rdata, 32'hDEADBEEF);
    check("tie_d_quiet", d_done, 1'b0);
    wait_done(1'b1, 20, td);
    check("tie_d_gap", td - tc, LAT + 2);
    check("wr_mem", mem[16], 32'h12345678);
    check("wr_keeps_c_rdata", c_rdata, 32'hDEADBEEF);
    check("wr_keeps_d_rdata", d_rdata, 32'h0);
    wait_idle(50);

    // Both ports saturated: strict alternation at one done per LAT+2 cycles.
    base = done_cnt; t_first = -1;
    for (int i = 0; i < 8; i++) begin
      push_rand(1'b0);
      push_rand(1'b1);
    end
    for (int i = 0; i < 400 && done_cnt < base + 16; i++) begin
      @(negedge clk); #1;
      if (t_first < 0 && done_cnt > base) t_first = last_done_cyc;
    end
    check("sat_done_count", done_cnt - base, 16);
    check("sat_spacing", last_done_cyc - t_first, 15 * (LAT + 2));
    wait_idle(50);

    // Reset during the second access cycle of a C read aborts it; the held request retries.
    push_op(1'b0, 1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b1) break;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_no_done", c_done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_we", writeEn, 1'b0);
    rst = 1'b0;
    wait_done(1'b0, 20, tc);
    check("abort_retry_rdata", c_rdata, 32'hA500_0020);
    wait_idle(50);

    // Randomized traffic with idle gaps on both ports.
    gaps = 1'b1;
    base = done_cnt;
    for (int i = 0; i < 30; i++) begin
      push_rand(1'b0);
      push_rand(1'b1);
    end
    wait_idle(4000);
    check("rand_done_count", done_cnt - base, 60);

    // LAT=1 instance: write then read-back from C, back to back.
    wv = $urandom;
    @(negedge clk); #1;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h20; c1_wdata = wv; t0 = cyc;
    tc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (c1_done === 1'b1) begin tc = cyc; break; end
    end
    c1_we = 1'b0; c1_wdata = $urandom;
    check("lat1_wr_latency", tc - t0, 2);
    td = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (c1_done === 1'b1) begin td = cyc; break; end
    end
    c1_req = 1'b0;
    check("lat1_period", td - tc, 3);
    check("lat1_rdata", c1_rdata, wv);
    check("lat1_mem", mem1[8], wv);
    check("lat1_d_quiet", {31'h0, d1_done}, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
